// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module   : datapath_pkg
// Brief    : Shared types and constants for the multi-cycle datapath:
//            opcodes, FSM state encoding, instruction field positions and
//            ALU control codes.
// Revision : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    // Instruction opcodes (op field, bits [31:28]); unlisted values are NOPs
    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADDI = 4'h1,
        OP_SUB  = 4'h2,
        OP_LW   = 4'h3,
        OP_SW   = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_NOR  = 4'h7,
        OP_SLT  = 4'h8,
        OP_BEQ  = 4'h9,
        OP_HALT = 4'hF
    } opcode_e;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_FETCH  = 3'd1;
    localparam logic [2:0] C_ST_DECODE = 3'd2;
    localparam logic [2:0] C_ST_EXEC   = 3'd3;
    localparam logic [2:0] C_ST_MEM    = 3'd4;
    localparam logic [2:0] C_ST_WB     = 3'd5;
    localparam logic [2:0] C_ST_HALT   = 3'd6;

    // Instruction field positions
    localparam int C_OP_LSB  = 28;
    localparam int C_OP_W    = 4;
    localparam int C_RS_LSB  = 24;
    localparam int C_RT_LSB  = 20;
    localparam int C_RD_LSB  = 16;
    localparam int C_IMM_LSB = 0;
    localparam int C_IMM_W   = 16;

    // ALU operation select
    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_NOR = 3'd3,
        ALU_SUB = 3'd4,
        ALU_SLT = 3'd5
    } alu_ctrl_e;

    // Map an opcode to the ALU operation it needs (address calc uses ADD)
    function automatic alu_ctrl_e alu_ctrl_of(input logic [3:0] op);
        alu_ctrl_e ctrl;
        case (op)
            OP_SUB, OP_BEQ: ctrl = ALU_SUB;
            OP_AND:         ctrl = ALU_AND;
            OP_OR:          ctrl = ALU_OR;
            OP_NOR:         ctrl = ALU_NOR;
            OP_SLT:         ctrl = ALU_SLT;
            default:        ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mc_regfile
// Brief    : Register file with two async read ports, an async debug read
//            port and one synchronous write port. Register 0 is never
//            written, so it always reads as zero. Async reset clears all.
// Revision : 1.0 - initial release
// ============================================================================
module mc_regfile
    import datapath_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr_a,
    output logic [XLEN-1:0] rdata_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_b,
    input  logic [AW-1:0]   dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] r_regs [NREG];

    // Storage: cleared on reset, writes to register 0 are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata_a   = r_regs[raddr_a];
    assign rdata_b   = r_regs[raddr_b];
    assign dbg_rdata = r_regs[dbg_raddr];

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_datapath
// Brief    : Multi-cycle processor datapath and controller. Instructions run
//            through FETCH/DECODE/EXEC/[MEM]/[WB]; instruction and data
//            memories are reached over req/ack handshakes so wait states
//            simply extend the FETCH or MEM state.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int PC_W = 8,
    parameter int DA_W = 8,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [DA_W-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            retire,
    output logic            halted,
    output logic [PC_W-1:0] pc,
    input  logic [AW-1:0]   dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu;
    logic [XLEN-1:0] r_mdr;

    logic [3:0]      w_op;
    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_res;
    logic [PC_W-1:0] w_pc4;
    logic [PC_W-1:0] w_br_tgt;
    logic            w_is_rtype;
    logic            w_uses_imm;
    logic            w_is_nop;
    logic            w_rf_we;
    logic [AW-1:0]   w_rf_waddr;
    logic [XLEN-1:0] w_rf_wdata;

    // Instruction field extraction
    assign w_op  = r_ir[C_OP_LSB +: C_OP_W];
    assign w_rs  = r_ir[C_RS_LSB +: AW];
    assign w_rt  = r_ir[C_RT_LSB +: AW];
    assign w_rd  = r_ir[C_RD_LSB +: AW];
    assign w_imm = XLEN'($signed(r_ir[C_IMM_LSB +: C_IMM_W]));

    // PC arithmetic wraps naturally at PC_W bits
    assign w_pc4    = r_pc + PC_W'(4);
    assign w_br_tgt = w_pc4 + PC_W'(w_imm << 2);

    // Opcode classification
    always_comb begin
        w_is_rtype = 1'b0;
        w_uses_imm = 1'b0;
        w_is_nop   = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT: w_is_rtype = 1'b1;
            OP_ADDI, OP_LW, OP_SW:                         w_uses_imm = 1'b1;
            OP_BEQ, OP_HALT:                               ;
            default:                                       w_is_nop   = 1'b1;
        endcase
    end

    // ALU: second operand is the immediate for ADDI/LW/SW, else B
    assign w_alu_b = w_uses_imm ? w_imm : r_b;

    // ALU operation select
    always_comb begin
        w_alu_res = '0;
        case (alu_ctrl_of(w_op))
            ALU_AND: w_alu_res = r_a & w_alu_b;
            ALU_OR:  w_alu_res = r_a | w_alu_b;
            ALU_NOR: w_alu_res = ~(r_a | w_alu_b);
            ALU_SUB: w_alu_res = r_a - w_alu_b;
            ALU_SLT: w_alu_res = XLEN'(r_a < w_alu_b);
            default: w_alu_res = r_a + w_alu_b;
        endcase
    end

    // Register write-back: R-type targets rd, ADDI/LW target rt
    assign w_rf_we    = (r_state == C_ST_WB);
    assign w_rf_waddr = w_is_rtype ? w_rd : w_rt;
    assign w_rf_wdata = (w_op == OP_LW) ? r_mdr : r_alu;

    mc_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a   (w_rs),
        .rdata_a   (w_rs_data),
        .raddr_b   (w_rt),
        .rdata_b   (w_rt_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (w_rf_we),
        .waddr     (w_rf_waddr),
        .wdata     (w_rf_wdata)
    );

    // Controller FSM plus PC, IR, A/B, ALU-out and MDR registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
        end else begin
            case (r_state)
                C_ST_IDLE: r_state <= C_ST_FETCH;
                C_ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= C_ST_DECODE;
                    end
                end
                C_ST_DECODE: begin
                    r_a     <= w_rs_data;
                    r_b     <= w_rt_data;
                    r_state <= C_ST_EXEC;
                end
                C_ST_EXEC: begin
                    r_alu <= w_alu_res;
                    if (w_op == OP_BEQ) begin
                        r_pc    <= (r_a == r_b) ? w_br_tgt : w_pc4;
                        r_state <= C_ST_FETCH;
                    end else if (w_is_nop) begin
                        r_pc    <= w_pc4;
                        r_state <= C_ST_FETCH;
                    end else if (w_op == OP_LW || w_op == OP_SW) begin
                        r_state <= C_ST_MEM;
                    end else if (w_op == OP_HALT) begin
                        r_state <= C_ST_HALT;
                    end else begin
                        r_state <= C_ST_WB;
                    end
                end
                C_ST_MEM: begin
                    if (dmem_ack) begin
                        if (w_op == OP_LW) begin
                            r_mdr   <= dmem_rdata;
                            r_state <= C_ST_WB;
                        end else begin
                            r_pc    <= w_pc4;
                            r_state <= C_ST_FETCH;
                        end
                    end
                end
                C_ST_WB: begin
                    r_pc    <= w_pc4;
                    r_state <= C_ST_FETCH;
                end
                C_ST_HALT: r_state <= C_ST_HALT;
                default:   r_state <= C_ST_IDLE;
            endcase
        end
    end

    // Handshake outputs are decoded from state so reset drops them at once;
    // the held registers keep addr/data stable while a request waits
    assign imem_req   = (r_state == C_ST_FETCH);
    assign imem_addr  = imem_req ? r_pc : '0;
    assign dmem_req   = (r_state == C_ST_MEM);
    assign dmem_we    = dmem_req && (w_op == OP_SW);
    assign dmem_addr  = dmem_req ? r_alu[DA_W-1:0] : '0;
    assign dmem_wdata = dmem_req ? r_b : '0;

    assign retire = ((r_state == C_ST_EXEC) && ((w_op == OP_BEQ) || w_is_nop))
                  || ((r_state == C_ST_MEM) && dmem_ack && (w_op == OP_SW))
                  || (r_state == C_ST_WB);
    assign halted = (r_state == C_ST_HALT);
    assign pc     = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_datapath
// Brief    : Directed, table-driven bench for multicycle_datapath with
//            hand-written sequences for reset-in-MEM and HALT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_datapath;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        retire;
    logic        halted;
    logic [7:0]  pc;
    logic [3:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    multicycle_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .retire     (retire),
        .halted     (halted),
        .pc         (pc),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        int          iwait;
        int          dwait;
        logic [31:0] drdata;
        int          cyc;
        logic [3:0]  rchk;
        logic [31:0] rval;
        logic [7:0]  epc;
        bit          dchk;
        logic        dwe;
        logic [7:0]  daddr;
        logic [31:0] dwd;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Run one instruction from its fetch to its retire, acting as both memories
    task automatic exec_instr(input vec_t v, output int cyc, output bit dreq_seen,
                              output logic dwe, output logic [7:0] daddr,
                              output logic [31:0] dwd, output bit addr_ok);
        int iw;
        int dw;
        int guard;
        bit done;
        logic [7:0] a0;
        guard = 0;
        while (!imem_req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        a0 = imem_addr;
        cyc = 0; iw = 0; dw = 0; done = 0; addr_ok = 1; dreq_seen = 0;
        dwe = 1'b0; daddr = '0; dwd = '0;
        while (!done && cyc < 40) begin
            cyc++;
            if (imem_req) begin
                if (imem_addr !== a0) addr_ok = 0;
                if (iw >= v.iwait) begin
                    imem_ack = 1'b1; imem_rdata = v.instr;
                end else begin
                    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF; iw++;
                end
            end else begin
                imem_ack = 1'b0;
            end
            if (dmem_req) begin
                dreq_seen = 1; dwe = dmem_we; daddr = dmem_addr; dwd = dmem_wdata;
                if (dw >= v.dwait) begin
                    dmem_ack = 1'b1; dmem_rdata = v.drdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD; dw++;
                end
            end else begin
                dmem_ack = 1'b0;
            end
            #1;
            if (retire) done = 1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc; bit dseen; logic dwe; logic [7:0] da; logic [31:0] dwd; bit aok;
        exec_instr(v, cyc, dseen, dwe, da, dwd, aok);
        dbg_raddr = v.rchk;
        #1;
        check({tag, " cycles"}, 64'(cyc), 64'(v.cyc));
        check({tag, " reg"}, 64'(dbg_rdata), 64'(v.rval));
        check({tag, " pc"}, 64'(pc), 64'(v.epc));
        check({tag, " imem_addr stable"}, 64'(aok), 64'd1);
        check({tag, " dmem_req seen"}, 64'(dseen), 64'(v.dchk));
        if (v.dchk) begin
            check({tag, " dmem_we"}, 64'(dwe), 64'(v.dwe));
            check({tag, " dmem_addr"}, 64'(da), 64'(v.daddr));
            if (v.dwe) check({tag, " dmem_wdata"}, 64'(dwd), 64'(v.dwd));
        end
    endtask

    initial begin
        int busy;
        int hcnt;
        int guard;
        vec_t v;

        //          instr         iw dw drdata        cyc reg rval          pc     dchk we  daddr  dwd
        tbl[0]  = '{32'h1010_0007, 0, 0, 32'h0,         4, 1, 32'h0000_0007, 8'h04, 0, 0, 8'h00, 32'h0};
        tbl[1]  = '{32'h0112_0000, 3, 0, 32'h0,         7, 2, 32'h0000_000E, 8'h08, 0, 0, 8'h00, 32'h0};
        tbl[2]  = '{32'h4020_0020, 0, 0, 32'h0,         4, 2, 32'h0000_000E, 8'h0C, 1, 1, 8'h20, 32'hE};
        tbl[3]  = '{32'h3030_0020, 0, 0, 32'h1234_5678, 5, 3, 32'h1234_5678, 8'h10, 1, 0, 8'h20, 32'h0};
        tbl[4]  = '{32'h9000_0001, 0, 0, 32'h0,         3, 0, 32'h0000_0000, 8'h18, 0, 0, 8'h00, 32'h0};
        tbl[5]  = '{32'h9100_0001, 0, 0, 32'h0,         3, 1, 32'h0000_0007, 8'h1C, 0, 0, 8'h00, 32'h0};
        tbl[6]  = '{32'h1000_FFFF, 0, 0, 32'h0,         4, 0, 32'h0000_0000, 8'h20, 0, 0, 8'h00, 32'h0};
        tbl[7]  = '{32'h2134_0000, 0, 0, 32'h0,         4, 4, 32'hEDCB_A98F, 8'h24, 0, 0, 8'h00, 32'h0};
        tbl[8]  = '{32'h6315_0000, 0, 0, 32'h0,         4, 5, 32'h1234_567F, 8'h28, 0, 0, 8'h00, 32'h0};
        tbl[9]  = '{32'h7316_0000, 0, 0, 32'h0,         4, 6, 32'hEDCB_A980, 8'h2C, 0, 0, 8'h00, 32'h0};
        tbl[10] = '{32'h8137_0000, 0, 0, 32'h0,         4, 7, 32'h0000_0001, 8'h30, 0, 0, 8'h00, 32'h0};
        tbl[11] = '{32'h8617_0000, 0, 0, 32'h0,         4, 7, 32'h0000_0000, 8'h34, 0, 0, 8'h00, 32'h0};
        tbl[12] = '{32'h5529_0000, 0, 0, 32'h0,         4, 9, 32'h0000_000E, 8'h38, 0, 0, 8'h00, 32'h0};
        tbl[13] = '{32'h16A0_8000, 0, 0, 32'h0,         4,10, 32'hEDCB_2980, 8'h3C, 0, 0, 8'h00, 32'h0};
        tbl[14] = '{32'hA000_0000, 0, 0, 32'h0,         3,10, 32'hEDCB_2980, 8'h40, 0, 0, 8'h00, 32'h0};
        tbl[15] = '{32'h4190_0004, 0, 2, 32'h0,         6, 9, 32'h0000_000E, 8'h44, 1, 1, 8'h0B, 32'hE};
        tbl[16] = '{32'h30B0_0000, 0, 1, 32'hCAFE_F00D, 6,11, 32'hCAFE_F00D, 8'h48, 1, 0, 8'h00, 32'h0};
        tbl[17] = '{32'h9000_FFFF, 0, 0, 32'h0,         3, 0, 32'h0000_0000, 8'h48, 0, 0, 8'h00, 32'h0};

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; dbg_raddr = '0;
        repeat (2) @(negedge clk);

        // Reset values
        check("rst imem_req", 64'(imem_req), 64'd0);
        check("rst imem_addr", 64'(imem_addr), 64'd0);
        check("rst dmem_req", 64'(dmem_req), 64'd0);
        check("rst dmem_we", 64'(dmem_we), 64'd0);
        check("rst dmem_addr", 64'(dmem_addr), 64'd0);
        check("rst dmem_wdata", 64'(dmem_wdata), 64'd0);
        check("rst retire", 64'(retire), 64'd0);
        check("rst halted", 64'(halted), 64'd0);
        check("rst pc", 64'(pc), 64'd0);

        rst = 1'b0;
        #1;
        check("idle imem_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("first imem_req", 64'(imem_req), 64'd1);
        check("first imem_addr", 64'(imem_addr), 64'd0);

        for (int i = 0; i < 18; i++) begin
            run_vec(tbl[i], $sformatf("v%0d", i));
        end

        // Reset while a load waits in MEM
        imem_ack = 1'b1; imem_rdata = 32'h3030_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        guard = 0;
        while (!dmem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("mid-mem dmem_req", 64'(dmem_req), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst dmem_req", 64'(dmem_req), 64'd0);
        check("async rst imem_req", 64'(imem_req), 64'd0);
        check("async rst pc", 64'(pc), 64'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-rst idle imem_req", 64'(imem_req), 64'd0);
        @(negedge clk);
        check("restart imem_req", 64'(imem_req), 64'd1);
        check("restart imem_addr", 64'(imem_addr), 64'd0);
        check("late ack dmem_req", 64'(dmem_req), 64'd0);
        dbg_raddr = 4'd3;
        #1;
        check("rst cleared r3", 64'(dbg_rdata), 64'd0);
        dmem_ack = 1'b0;
        v = '{32'h1010_0007, 0, 0, 32'h0, 4, 1, 32'h7, 8'h04, 0, 0, 8'h00, 32'h0};
        run_vec(v, "restart");

        // HALT: terminal, silent, cleared only by reset
        imem_ack = 1'b1; imem_rdata = 32'hF000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("halted", 64'(halted), 64'd1);
        busy = 0; hcnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (imem_req || dmem_req || retire) busy++;
            if (halted) hcnt++;
        end
        check("halt activity", 64'(busy), 64'd0);
        check("halt held", 64'(hcnt), 64'd20);
        check("halt pc", 64'(pc), 64'h04);
        #2 rst = 1'b1;
        #1;
        check("rst clears halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle processor datapath and controller. It runs one instruction over 3–5 cycles through an FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT). Instruction and data memories sit outside the block and are reached through req/ack handshake ports, so memories with wait states can be attached. It is the top compute block of the core, between the instruction memory and the data memory.

## Interface
- XLEN, 32: datapath and register width (≥16)
- NREG, 16: register count, power of two ≤16; r0 reads as 0
- PC_W, 8: PC and imem address width
- DA_W, 8: dmem address width (byte address, low DA_W bits of ALU result)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; imem_addr  out  PC_W  fetch byte address
- imem_ack  in  1  fetch complete; imem_rdata  in  32  instruction, valid when imem_ack
- dmem_req  out  1; dmem_we  out  1  1 = store; dmem_addr  out  DA_W; dmem_wdata  out  XLEN
- dmem_ack  in  1; dmem_rdata  in  XLEN  load data, valid when dmem_ack
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  high in HALT
- pc  out  PC_W  current PC
- dbg_raddr  in  log2(NREG); dbg_rdata  out  XLEN  combinational register read

## Operation
- Instruction fields: op[31:28], rs[27:24], rt[23:20], rd[19:16], imm[15:0]. Register indices use the low log2(NREG) bits. imm is sign-extended to XLEN.
- Opcodes:
  - 0 ADD, 2 SUB, 5 AND, 6 OR, 7 NOR, 8 SLT (unsigned): rd ← rs op rt
  - 1 ADDI: rt ← rs+imm
  - 3 LW: rt ← mem[rs+imm]
  - 4 SW: mem[rs+imm] ← rt
  - 9 BEQ: if rs==rt then pc ← pc+4+(imm<<2)
  - F HALT
  - Any other opcode is a NOP.
- Arithmetic wraps mod 2^XLEN. PC wraps mod 2^PC_W. Every non-branch instruction ends with pc ← pc+4.
- A write to r0 is discarded. Register file contents reset to 0.
- State transitions:
  - IDLE → FETCH.
  - FETCH: imem_req=1 and imem_addr=pc; stay until imem_ack, then latch IR → DECODE.
  - DECODE: read rs/rt into A/B → EXEC.
  - EXEC: ALU operation.
    - BEQ/NOP: update pc, retire → FETCH.
    - LW/SW → MEM.
    - HALT → HALT.
    - Others → WB.
  - MEM: dmem_req=1 and hold addr/we/wdata; stay until dmem_ack.
    - LW: latch MDR → WB.
    - SW: pc+4, retire → FETCH.
  - WB: write the register, pc+4, retire → FETCH.
  - HALT: terminal until rst; retire=0, halted=1.

## Timing
- Reset values: state IDLE, pc 0, IR 0; all req, we, and retire outputs 0; imem_addr, dmem_addr, and dmem_wdata 0; halted 0.
- First imem_req rises the cycle after rst deasserts (IDLE lasts one cycle).
- With zero-wait memories (ack in the same cycle as req), cycles per instruction are:
  - ALU/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/NOP: 3
  - Each wait cycle adds 1.
- req and its address/data are stable from assertion until the ack edge. req drops the cycle after ack.
- Back-to-back fetches therefore have at least one req-low cycle between them.
- Handshake corner cases:
  - An ack while the matching req is low is ignored.
  - rdata is sampled only on the ack edge.
- Reset during an outstanding request abandons it: req drops immediately (asynchronously). An ack arriving after reset is ignored.
- The register write in WB takes effect at the WB edge. dbg_rdata reflects it in the next cycle.
- retire is asserted in the final cycle of an instruction, and pc is updated on that same edge.

## Structure
- Shared package datapath_pkg holds:
  - opcode enum
  - FSM state enum
  - instruction field position constants
  - ALU control enum (AND, OR, ADD, NOR, SUB, SLT)
- Sub-module mc_regfile: parametrised by XLEN and NREG, with two async read ports, one debug read port, one sync write port, and async reset clearing. The FSM, ALU, and PC logic stay in the top module.

## Test plan
- Reset, then zero-wait fetch of 0x1010_0007 (ADDI r1,r0,7) → retire on the 4th cycle after IDLE; dbg r1=7; pc=4.
- Next instruction 0x0112_0000 (ADD r2,r1,r1), with imem_ack delayed 3 cycles → r2=14; imem_addr=4 held stable through the wait; 7 cycles total.
- 0x4020_0020 (SW r2,0x20(r0)) → one dmem_req with we=1, addr=0x20, wdata=0xE; 0x3030_0020 (LW r3) with dmem_rdata=0x1234_5678 → r3=0x1234_5678, 5 cycles.
- At pc=0x10, 0x9000_0001 (BEQ r0,r0,+1) → next imem_addr=0x18 after 3 cycles; with rs≠rt → 0x14. 0x1000_FFFF writing r0 → r0 stays 0.
- Assert rst mid-MEM while dmem_req is high → req low immediately, pc=0; a late dmem_ack is ignored; the fetch restarts from 0.
- 0xF000_0000 → halted=1; no further req and retire stays 0 for 20 cycles; rst clears halted.
